xgxs_tx_idle_seq: RTL and testbench

- Transmit column sequencer for the XGXS PCS. It sits between the XGMII-side transmit column (4 lanes × 8 bits + 4 control flags) and four 8b/10b encoder lanes.
- Translates XGMII idle columns into the XAUI ||A||/||K||/||R|| idle pattern with pseudo-random /A/ spacing. Passes data through. Maps unsupported control characters to the encoder's error code-group.
- Guarantees the encoder's konstant input is asserted only with 8'h1C (/R/ K28.0), 8'h7C (/A/ K28.3) or 8'hBC (/K/ K28.5).

---
 rtl/xgxs_pcs_pkg.sv | 27 ++
 rtl/xgxs_idle_lfsr.sv | 28 ++
 rtl/xgxs_tx_idle_seq.sv | 126 ++++++++++++
 tb/tb_xgxs_tx_idle_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/xgxs_pcs_pkg.sv
// Shared XGXS PCS constants: XGMII idle byte, idle code-groups, sequencer states
// and the idle-pattern LFSR definition.
package xgxs_pcs_pkg;

   localparam logic [7:0] XGMII_IDLE = 8'h07;
   localparam logic [7:0] CG_K       = 8'hBC;  // K28.5
   localparam logic [7:0] CG_R       = 8'h1C;  // K28.0
   localparam logic [7:0] CG_A       = 8'h7C;  // K28.3
   localparam logic [7:0] CG_ERR     = 8'h00;  // data byte sent alongside bad_code

   typedef enum logic {
      IDLE_FIRST = 1'b0,
      IDLE_RUN   = 1'b1
   } idle_state_e;

   // x^7 + x^6 + 1, Fibonacci form, feedback shifted into bit 0
   localparam int LFSR_W      = 7;
   localparam int LFSR_TAP_HI = 6;
   localparam int LFSR_TAP_LO = 5;
   localparam int LFSR_RK_BIT = 4;
   localparam int LFSR_SPC_W  = 4;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
   endfunction

endpackage

// File: rtl/xgxs_idle_lfsr.sv
// Idle-pattern LFSR: provides the R/K select bit and the /A/ spacing nibble.
// Shared by the transmit sequencer and the receive-side idle checker.
module xgxs_idle_lfsr
   import xgxs_pcs_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 7'h7F
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic                  rk_bit,
   output logic [LFSR_SPC_W-1:0] spacing
);

   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (en) begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   assign rk_bit  = lfsr[LFSR_RK_BIT];
   assign spacing = lfsr[LFSR_SPC_W-1:0];

endmodule

// File: rtl/xgxs_tx_idle_seq.sv
// XGXS transmit column sequencer: XGMII idle columns become ||A||/||K||/||R||,
// data passes through, unsupported control bytes become error code-groups.
module xgxs_tx_idle_seq
   import xgxs_pcs_pkg::*;
#(
   parameter int                LANES     = 4,
   parameter int                A_MIN     = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 7'h7F
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*LANES-1:0]   txd,
   input  logic [LANES-1:0]     txc,
   input  logic [LANES-1:0]     err_inj,
   output logic [8*LANES-1:0]   enc_data,
   output logic [LANES-1:0]     enc_konstant,
   output logic [LANES-1:0]     enc_bad_code,
   output logic [LANES-1:0]     enc_bad_disp,
   output logic                 a_sent
);

   localparam logic [4:0] A_BASE = 5'(A_MIN - 1);

   idle_state_e           state, state_nxt;
   logic [4:0]            a_cnt, a_cnt_nxt;
   logic                  rk_bit;
   logic [LFSR_SPC_W-1:0] spacing;
   logic [LANES-1:0]      lane_idle;
   logic                  col_idle;
   logic                  send_a;
   logic [7:0]            cg;
   logic [8*LANES-1:0]    data_d;
   logic [LANES-1:0]      konst_d;
   logic [LANES-1:0]      bad_d;

   xgxs_idle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .en      (1'b1),
      .rk_bit  (rk_bit),
      .spacing (spacing)
   );

   assign col_idle = &lane_idle;

   // Column-level idle decision; a_cnt runs through data so /A/ spacing is kept.
   always_comb begin
      state_nxt = state;
      send_a    = 1'b0;
      cg        = CG_K;
      if (col_idle) begin
         state_nxt = IDLE_RUN;
         if (a_cnt == 5'd0) begin
            send_a = 1'b1;
            cg     = CG_A;
         end else if (state == IDLE_RUN && rk_bit) begin
            cg = CG_R;
         end
      end else begin
         state_nxt = IDLE_FIRST;
      end

      if (send_a) begin
         a_cnt_nxt = A_BASE + {1'b0, spacing};
      end else if (a_cnt != 5'd0) begin
         a_cnt_nxt = a_cnt - 5'd1;
      end else begin
         a_cnt_nxt = 5'd0;
      end
   end

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      logic [7:0] lane_byte;
      logic [7:0] d;
      logic       k;
      logic       bc;

      assign lane_byte    = txd[8*n +: 8];
      assign lane_idle[n] = txc[n] && (lane_byte == XGMII_IDLE);

      always_comb begin
         d  = CG_ERR;
         k  = 1'b0;
         bc = 1'b0;
         if (err_inj[n]) begin
            bc = 1'b1;
         end else if (col_idle) begin
            d = cg;
            k = 1'b1;
         end else if (!txc[n]) begin
            d = lane_byte;
         end else if (lane_idle[n]) begin
            // idle lane inside a non-idle column never carries /A/ or /R/
            d = CG_K;
            k = 1'b1;
         end else begin
            bc = 1'b1;
         end
      end

      assign data_d[8*n +: 8] = d;
      assign konst_d[n]       = k;
      assign bad_d[n]         = bc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE_FIRST;
         a_cnt        <= 5'd0;
         enc_data     <= '0;
         enc_konstant <= '0;
         enc_bad_code <= '0;
         a_sent       <= 1'b0;
      end else begin
         state        <= state_nxt;
         a_cnt        <= a_cnt_nxt;
         enc_data     <= data_d;
         enc_konstant <= konst_d;
         enc_bad_code <= bad_d;
         a_sent       <= send_a;
      end
   end

   assign enc_bad_disp = '0;

endmodule

// File: tb/tb_xgxs_tx_idle_seq.sv
// Bench for xgxs_tx_idle_seq: hand-computed column table after reset, reset
// mid-burst sequence, and a long idle run against a reference idle model.
module tb_xgxs_tx_idle_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] txd;
   logic [3:0]  txc;
   logic [3:0]  err_inj;
   logic [31:0] enc_data;
   logic [3:0]  enc_konstant;
   logic [3:0]  enc_bad_code;
   logic [3:0]  enc_bad_disp;
   logic        a_sent;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] IDLE_D = 32'h07070707;

   typedef struct {
      logic [31:0] txd;
      logic [3:0]  txc;
      logic [3:0]  err;
      logic [31:0] exp_data;
      logic [3:0]  exp_k;
      logic [3:0]  exp_bc;
      logic        exp_a;
   } vec_t;

   vec_t vecs[40];

   xgxs_tx_idle_seq dut (
      .clk          (clk),
      .rst          (rst),
      .txd          (txd),
      .txc          (txc),
      .err_inj      (err_inj),
      .enc_data     (enc_data),
      .enc_konstant (enc_konstant),
      .enc_bad_code (enc_bad_code),
      .enc_bad_disp (enc_bad_disp),
      .a_sent       (a_sent)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [44:0] got();
      return {enc_data, enc_konstant, enc_bad_code, enc_bad_disp, a_sent};
   endfunction

   function automatic vec_t mk(input logic [31:0] d, input logic [3:0] c, input logic [3:0] e,
                               input logic [31:0] xd, input logic [3:0] xk,
                               input logic [3:0] xbc, input logic xa);
      vec_t v;
      v.txd = d; v.txc = c; v.err = e;
      v.exp_data = xd; v.exp_k = xk; v.exp_bc = xbc; v.exp_a = xa;
      return v;
   endfunction

   function automatic vec_t idle_v(input logic [7:0] cg);
      return mk(IDLE_D, 4'hF, 4'h0, {4{cg}}, 4'hF, 4'h0, cg == 8'h7C);
   endfunction

   task automatic check(input string name, input logic [44:0] act, input logic [44:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got data=%h k=%h bc=%h bd=%h a=%b, want data=%h k=%h bc=%h bd=%h a=%b",
                  name, act[44:13], act[12:9], act[8:5], act[4:1], act[0],
                  exp[44:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   // driver: present one column, then sample 1 time unit after the edge
   task automatic drive(input logic [31:0] d, input logic [3:0] c, input logic [3:0] e);
      txd = d; txc = c; err_inj = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_rst_async"}, got(), 45'h0);
      @(posedge clk);
      #1;
      check({tag, "_rst_hold"}, got(), 45'h0);
      rst = 1'b0;
   endtask

   // reference idle model state
   logic [6:0] m_lfsr;
   logic [4:0] m_acnt;
   logic       m_first;

   task automatic model_idle(input logic [3:0] e, output logic [44:0] exp);
      logic [7:0]  cg;
      logic        a;
      logic [31:0] d;
      logic [3:0]  k;
      a = 1'b0;
      if (m_acnt == 5'd0) begin
         cg = 8'h7C;
         a = 1'b1;
         m_acnt = 5'd15 + {1'b0, m_lfsr[3:0]};
      end else begin
         cg = (!m_first && m_lfsr[4]) ? 8'h1C : 8'hBC;
         m_acnt = m_acnt - 5'd1;
      end
      m_first = 1'b0;
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      for (int l = 0; l < 4; l++) begin
         d[8*l +: 8] = e[l] ? 8'h00 : cg;
         k[l]        = ~e[l];
      end
      exp = {d, k, e, 4'h0, a};
   endtask

   initial begin
      logic [44:0] exp;
      int          last_a;
      int          found;
      logic        legal;

      // column table after reset (LFSR sequence from 7F worked by hand)
      vecs[0] = idle_v(8'h7C);
      for (int i = 1; i <= 4; i++) vecs[i] = idle_v(8'h1C);
      for (int i = 5; i <= 10; i++) vecs[i] = idle_v(8'hBC);
      vecs[11] = idle_v(8'h1C);
      for (int i = 12; i <= 16; i++) vecs[i] = idle_v(8'hBC);
      vecs[17] = idle_v(8'h1C);
      vecs[18] = idle_v(8'h1C);
      for (int i = 19; i <= 22; i++) vecs[i] = idle_v(8'hBC);
      vecs[23] = idle_v(8'h1C);
      vecs[24] = idle_v(8'hBC);
      vecs[25] = idle_v(8'h1C);
      for (int i = 26; i <= 28; i++) vecs[i] = idle_v(8'hBC);
      vecs[29] = idle_v(8'h1C);
      vecs[30] = idle_v(8'h1C);
      vecs[31] = idle_v(8'h7C);
      vecs[32] = mk(32'hDEADBEEF, 4'h0, 4'h0, 32'hDEADBEEF, 4'h0, 4'h0, 1'b0);
      vecs[33] = idle_v(8'hBC);
      vecs[34] = mk(32'h555555FB, 4'h1, 4'h0, 32'h55555500, 4'h0, 4'h1, 1'b0);
      vecs[35] = mk(32'h07070755, 4'hF, 4'h0, 32'hBCBCBC00, 4'hE, 4'h1, 1'b0);
      vecs[36] = mk(32'h07071234, 4'hC, 4'h0, 32'hBCBC1234, 4'hC, 4'h0, 1'b0);
      vecs[37] = idle_v(8'hBC);
      vecs[38] = mk(IDLE_D, 4'hF, 4'h4, 32'hBC00BCBC, 4'hB, 4'h4, 1'b0);
      vecs[39] = idle_v(8'h1C);

      txd = IDLE_D; txc = 4'hF; err_inj = 4'h0;
      do_reset("init");
      for (int i = 0; i < 40; i++) begin
         drive(vecs[i].txd, vecs[i].txc, vecs[i].err);
         check($sformatf("col%0d", i), got(),
               {vecs[i].exp_data, vecs[i].exp_k, vecs[i].exp_bc, 4'h0, vecs[i].exp_a});
      end

      // reset during a data burst; a_cnt stays 0 across data, A on first idle
      drive(32'h11223344, 4'h0, 4'h0);
      check("burst_data", got(), {32'h11223344, 4'h0, 4'h0, 4'h0, 1'b0});
      rst = 1'b1;
      #1;
      check("burst_rst_async", got(), 45'h0);
      txd = 32'h99887766;
      @(posedge clk);
      #1;
      check("burst_rst_hold", got(), 45'h0);
      rst = 1'b0;
      drive(32'hA5A5A5A5, 4'h0, 4'h0);
      check("post_rst_data", got(), {32'hA5A5A5A5, 4'h0, 4'h0, 4'h0, 1'b0});
      drive(IDLE_D, 4'hF, 4'h0);
      check("post_rst_a", got(), {32'h7C7C7C7C, 4'hF, 4'h0, 4'h0, 1'b1});
      // LFSR restarted at 7F: column 1 sees 7E, reload 29, next A 30 columns on
      found = 0;
      for (int i = 2; i < 40 && found == 0; i++) begin
         drive(IDLE_D, 4'hF, 4'h0);
         if (a_sent) found = i;
      end
      n_checks++;
      if (found != 31) begin
         n_fail++;
         $display("FAIL post_rst_next_a: got column %0d want 31", found);
      end

      // long idle run against the reference model, with lane-2 injections
      txd = IDLE_D; txc = 4'hF; err_inj = 4'h0;
      do_reset("long");
      m_lfsr = 7'h7F; m_acnt = 5'd0; m_first = 1'b1;
      last_a = -1;
      for (int i = 0; i < 10000; i++) begin
         logic [3:0] e;
         e = (i == 100 || i == 5000 || i == 7777) ? 4'b0100 : 4'b0000;
         drive(IDLE_D, 4'hF, e);
         model_idle(e, exp);
         check($sformatf("long%0d", i), got(), exp);
         legal = 1'b1;
         for (int l = 0; l < 4; l++) begin
            if (enc_konstant[l] && !(enc_data[8*l +: 8] inside {8'h1C, 8'h7C, 8'hBC}))
               legal = 1'b0;
         end
         check_bit($sformatf("konst_legal%0d", i), legal, 1'b1);
         if (a_sent) begin
            if (last_a >= 0) begin
               n_checks++;
               if (i - last_a < 16 || i - last_a > 31) begin
                  n_fail++;
                  $display("FAIL a_gap%0d: got %0d want 16..31", i, i - last_a);
               end
            end
            last_a = i;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
